// File: rtl/ov7670_sensor_pkg.sv
// Shared types and helpers for the OV7670 sensor model: frame state encoding,
// byte-per-pixel constant and the RGB444 test-pattern byte generator.
package ov7670_sensor_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_VSYNC  = 3'd1,
        ST_VBACK  = 3'd2,
        ST_ACTIVE = 3'd3,
        ST_VFRONT = 3'd4
    } state_t;

    // RGB444 is carried as two bytes per pixel: {0,R} then {G,B}.
    localparam int BYTES_PER_PIXEL = 2;

    // Pattern byte for one pixel half: red follows the column, green the row,
    // blue the frame number, each taken from the upper nibble (blue: low nibble).
    function automatic logic [7:0] rgb444_byte(
        input logic [7:0] col,
        input logic [7:0] row,
        input logic [3:0] frame,
        input logic       odd
    );
        if (odd) begin
            return {row[7:4], frame};
        end
        return {4'h0, col[7:4]};
    endfunction

endpackage

// File: rtl/ov7670_sensor_model.sv
// OV7670 camera-side transmitter model: free-running PCLK at clk_i/2, VSYNC,
// HREF and RGB444 pattern bytes framed by configurable blanking.
// Optional status ports (frame_done_o, frame_cnt_o) are built when the macro
// OV7670_SENSOR_MODEL_STATUS_EN is defined.
module ov7670_sensor_model
    import ov7670_sensor_pkg::*;
#(
    parameter int ACTIVE_COLUMNS = 640,
    parameter int ACTIVE_ROWS    = 480,
    parameter int HBLANK_BYTES   = 288,
    parameter int VSYNC_LINES    = 3,
    parameter int VBACK_LINES    = 17,
    parameter int VFRONT_LINES   = 10
) (
    input  logic       clk_i,
    input  logic       reset_i,
    input  logic       en_i,
    output logic       pclk_o,
    output logic       vsync_o,
    output logic       href_o,
    output logic [7:0] data_o,
    output logic       busy_o
`ifdef OV7670_SENSOR_MODEL_STATUS_EN
    ,
    output logic        frame_done_o,
    output logic [15:0] frame_cnt_o
`endif
);

    localparam int ACTIVE_BYTES = BYTES_PER_PIXEL * ACTIVE_COLUMNS;
    localparam int LINE_BYTES   = ACTIVE_BYTES + HBLANK_BYTES;
    localparam int MAX_LINES_A  = (ACTIVE_ROWS > VSYNC_LINES) ? ACTIVE_ROWS : VSYNC_LINES;
    localparam int MAX_LINES_B  = (VBACK_LINES > VFRONT_LINES) ? VBACK_LINES : VFRONT_LINES;
    localparam int MAX_LINES    = (MAX_LINES_A > MAX_LINES_B) ? MAX_LINES_A : MAX_LINES_B;
    localparam int BYTE_W       = (LINE_BYTES > 1) ? $clog2(LINE_BYTES) : 1;
    localparam int LINE_W       = (MAX_LINES > 1) ? $clog2(MAX_LINES) : 1;

    state_t              state;
    state_t              state_next;
    logic [BYTE_W-1:0]   byte_cnt;
    logic [LINE_W-1:0]   line_cnt;
    logic [15:0]         frame_cnt;
    logic                pclk;
    logic                line_done;
    logic                frame_exit;
    logic                vsync_d;
    logic                href_d;
    logic [7:0]          data_d;
    logic                busy_d;

    // A tick is the clk_i cycle with pclk high; everything but pclk advances
    // on ticks, so outputs move together with the falling edge of pclk.
    assign pclk_o    = pclk;
    assign line_done = (byte_cnt == BYTE_W'(LINE_BYTES - 1));

    // Next-state: count whole lines per state, leave on the last byte of the last line.
    // NOTE: every combinational output gets a default first so no latch can be inferred.
    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: begin
                if (en_i) state_next = ST_VSYNC;
            end
            ST_VSYNC: begin
                if (line_done && line_cnt == LINE_W'(VSYNC_LINES - 1)) state_next = ST_VBACK;
            end
            ST_VBACK: begin
                if (line_done && line_cnt == LINE_W'(VBACK_LINES - 1)) state_next = ST_ACTIVE;
            end
            ST_ACTIVE: begin
                if (line_done && line_cnt == LINE_W'(ACTIVE_ROWS - 1)) state_next = ST_VFRONT;
            end
            ST_VFRONT: begin
                if (line_done && line_cnt == LINE_W'(VFRONT_LINES - 1)) begin
                    state_next = en_i ? ST_VSYNC : ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // Output decode for the byte at the current counter position; registered on the tick.
    always_comb begin
        vsync_d    = (state == ST_VSYNC);
        href_d     = (state == ST_ACTIVE) && (byte_cnt < BYTE_W'(ACTIVE_BYTES));
        busy_d     = (state != ST_IDLE);
        frame_exit = (state == ST_VFRONT) && (state_next != ST_VFRONT);
        data_d     = 8'h00;
        if (href_d) begin
            data_d = rgb444_byte(8'(byte_cnt >> 1), 8'(line_cnt), frame_cnt[3:0], byte_cnt[0]);
        end
    end

    // State, counters and the one-tick output pipeline.
    // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            pclk      <= 1'b0;
            state     <= ST_IDLE;
            byte_cnt  <= '0;
            line_cnt  <= '0;
            frame_cnt <= '0;
            vsync_o   <= 1'b0;
            href_o    <= 1'b0;
            data_o    <= 8'h00;
            busy_o    <= 1'b0;
`ifdef OV7670_SENSOR_MODEL_STATUS_EN
            frame_done_o <= 1'b0;
`endif
        end else begin
            pclk <= ~pclk;
`ifdef OV7670_SENSOR_MODEL_STATUS_EN
            frame_done_o <= pclk && frame_exit;
`endif
            if (pclk) begin
                state <= state_next;
                if (state_next != state) begin
                    byte_cnt <= '0;
                    line_cnt <= '0;
                end else if (state != ST_IDLE) begin
                    if (line_done) begin
                        byte_cnt <= '0;
                        line_cnt <= line_cnt + 1'b1;
                    end else begin
                        byte_cnt <= byte_cnt + 1'b1;
                    end
                end
                if (frame_exit) frame_cnt <= frame_cnt + 16'd1;
                vsync_o <= vsync_d;
                href_o  <= href_d;
                data_o  <= data_d;
                busy_o  <= busy_d;
            end
        end
    end

`ifdef OV7670_SENSOR_MODEL_STATUS_EN
    assign frame_cnt_o = frame_cnt;
`else
    // Without the status ports frame_cnt only feeds the blue channel of the pattern.
`endif

endmodule

// File: tb/tb_ov7670_sensor_model.sv
// Testbench for ov7670_sensor_model: two instances (4x3 and 32x17 active
// areas) checked every clk_i cycle against a frame-position model, plus
// literal checks of sync widths, frame period and sampled pattern bytes.
module tb_ov7670_sensor_model;

    localparam int HB = 4;
    localparam int VS = 1;
    localparam int VB = 1;
    localparam int VF = 1;
    localparam int P_COLS [2] = '{4, 32};
    localparam int P_ROWS [2] = '{3, 17};

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic en  = 1'b0;

    logic       pclk_a, vs_a, hr_a, busy_a;
    logic [7:0] data_a;
    logic       pclk_b, vs_b, hr_b, busy_b;
    logic [7:0] data_b;
`ifdef OV7670_SENSOR_MODEL_STATUS_EN
    logic        done_a, done_b;
    logic [15:0] fcnt_a, fcnt_b;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    ov7670_sensor_model #(
        .ACTIVE_COLUMNS(4), .ACTIVE_ROWS(3), .HBLANK_BYTES(HB),
        .VSYNC_LINES(VS), .VBACK_LINES(VB), .VFRONT_LINES(VF)
    ) dut_a (
        .clk_i(clk), .reset_i(rst), .en_i(en),
        .pclk_o(pclk_a), .vsync_o(vs_a), .href_o(hr_a), .data_o(data_a), .busy_o(busy_a)
`ifdef OV7670_SENSOR_MODEL_STATUS_EN
        , .frame_done_o(done_a), .frame_cnt_o(fcnt_a)
`endif
    );

    ov7670_sensor_model #(
        .ACTIVE_COLUMNS(32), .ACTIVE_ROWS(17), .HBLANK_BYTES(HB),
        .VSYNC_LINES(VS), .VBACK_LINES(VB), .VFRONT_LINES(VF)
    ) dut_b (
        .clk_i(clk), .reset_i(rst), .en_i(en),
        .pclk_o(pclk_b), .vsync_o(vs_b), .href_o(hr_b), .data_o(data_b), .busy_o(busy_b)
`ifdef OV7670_SENSOR_MODEL_STATUS_EN
        , .frame_done_o(done_b), .frame_cnt_o(fcnt_b)
`endif
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Expected {vsync, href, busy, data} for absolute byte position pos in a frame
    // (pos < 0 means idle), derived from the line layout of instance i.
    function automatic logic [10:0] model_out(int pos, int frame, int i);
        int lb, line, b, row, col;
        logic [10:0] r;
        r = '0;
        if (pos >= 0) begin
            lb   = 2 * P_COLS[i] + HB;
            line = pos / lb;
            b    = pos % lb;
            row  = line - VS - VB;
            r[8] = 1'b1;
            if (line < VS) r[10] = 1'b1;
            if (row >= 0 && row < P_ROWS[i] && b < 2 * P_COLS[i]) begin
                r[9] = 1'b1;
                col  = b / 2;
                if (b % 2 == 1) r[7:0] = 8'(((row / 16) % 16) * 16 + frame % 16);
                else            r[7:0] = 8'((col / 16) % 16);
            end
        end
        return r;
    endfunction

    function automatic int frame_bytes(int i);
        return (2 * P_COLS[i] + HB) * (VS + VB + P_ROWS[i] + VF);
    endfunction

    // Reference model: frame position advances one byte per pclk period.
    logic        m_pclk;
    int          m_pos   [2];
    int          m_frame [2];
    int          m_cur   [2];
    int          m_cur_fr[2];
    logic [10:0] m_exp   [2];
    logic        m_done  [2];

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_pclk <= 1'b0;
            for (int i = 0; i < 2; i++) begin
                m_pos[i] <= -1; m_frame[i] <= 0; m_cur[i] <= -1; m_cur_fr[i] <= 0;
                m_exp[i] <= '0; m_done[i] <= 1'b0;
            end
        end else begin
            m_pclk <= !m_pclk;
            for (int i = 0; i < 2; i++) begin
                m_done[i] <= 1'b0;
                if (m_pclk) begin
                    m_exp[i]    <= model_out(m_pos[i], m_frame[i], i);
                    m_cur[i]    <= m_pos[i];
                    m_cur_fr[i] <= m_frame[i];
                    if (m_pos[i] < 0) begin
                        if (en) m_pos[i] <= 0;
                    end else if (m_pos[i] == frame_bytes(i) - 1) begin
                        m_frame[i] <= (m_frame[i] + 1) % 65536;
                        m_done[i]  <= 1'b1;
                        m_pos[i]   <= en ? 0 : -1;
                    end else begin
                        m_pos[i] <= m_pos[i] + 1;
                    end
                end
            end
        end
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Statistics for instance A, gathered at pclk-high samples (receiver view).
    int         vs_rises = 0;
    logic       prev_vs = 1'b0, prev_hr = 1'b0;
    int         rise_cyc [4];
    int         vs_cnt [4];
    int         hp_cnt [4];
    int         hr_cnt [4];
    int         hidx   [4];
    logic [7:0] f0_bytes [8];
    logic [7:0] f1_odd   [4];
    logic [7:0] b_col16 = 8'hEE;
    logic [7:0] b_row16 = 8'hEE;
    logic       after_drop = 1'b0;
    int         vs_after = 0;
`ifdef OV7670_SENSOR_MODEL_STATUS_EN
    int         done_cyc [3];
    int         n_done = 0;
    logic [15:0] fcnt_at_vs [3];
`endif

    initial begin
        for (int k = 0; k < 4; k++) begin
            rise_cyc[k] = 0; vs_cnt[k] = 0; hp_cnt[k] = 0; hr_cnt[k] = 0; hidx[k] = 0;
            f1_odd[k] = 8'hEE;
        end
        for (int k = 0; k < 8; k++) f0_bytes[k] = 8'hEE;
    end

    // Compare process: every cycle out of reset, both instances against the model.
    always @(negedge clk) begin
        int f, line, b;
        if (!rst) begin
            check("out_a", {21'd0, pclk_a, vs_a, hr_a, busy_a, data_a}, {21'd0, m_pclk, m_exp[0]});
            check("out_b", {21'd0, pclk_b, vs_b, hr_b, busy_b, data_b}, {21'd0, m_pclk, m_exp[1]});
`ifdef OV7670_SENSOR_MODEL_STATUS_EN
            check("status_a", {15'd0, done_a, fcnt_a}, {15'd0, m_done[0], 16'(m_frame[0])});
            check("status_b", {15'd0, done_b, fcnt_b}, {15'd0, m_done[1], 16'(m_frame[1])});
            if (done_a) begin
                if (n_done < 3) done_cyc[n_done] <= cyc;
                n_done <= n_done + 1;
            end
`endif
            if (pclk_a) begin
                if (vs_a && !prev_vs) begin
                    f = vs_rises;
                    vs_rises <= vs_rises + 1;
                    if (f < 4) rise_cyc[f] <= cyc;
`ifdef OV7670_SENSOR_MODEL_STATUS_EN
                    if (f < 3) fcnt_at_vs[f] <= fcnt_a;
`endif
                end else begin
                    f = vs_rises - 1;
                end
                if (f >= 0 && f < 4) begin
                    if (vs_a) vs_cnt[f] <= vs_cnt[f] + 1;
                    if (hr_a) begin
                        hp_cnt[f] <= hp_cnt[f] + 1;
                        hidx[f]   <= hidx[f] + 1;
                        if (f == 0 && hidx[f] < 8) f0_bytes[hidx[f]] <= data_a;
                        if (f == 1 && hidx[f] < 8 && hidx[f] % 2 == 1) f1_odd[hidx[f] / 2] <= data_a;
                    end
                    if (hr_a && !prev_hr) hr_cnt[f] <= hr_cnt[f] + 1;
                end
                if (after_drop && vs_a) vs_after <= vs_after + 1;
                prev_vs <= vs_a;
                prev_hr <= hr_a;
            end
            if (pclk_b && m_cur[1] >= 0) begin
                line = m_cur[1] / (2 * P_COLS[1] + HB);
                b    = m_cur[1] % (2 * P_COLS[1] + HB);
                if (m_cur_fr[1] == 0 && line == VS + VB && b == 32) b_col16 <= data_b;
                if (m_cur_fr[1] == 11 && line == VS + VB + 16 && b == 1) b_row16 <= data_b;
            end
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        int   toggles;
        logic prev_pclk;
        logic found;

        // Model pins from hand-computed values.
        check("model_vsync_byte", 32'(model_out(5, 0, 0)), 32'h500);
        check("model_col16",      32'(model_out(2 * 68 + 32, 0, 1)), 32'h301);
        check("model_row16",      32'(model_out(18 * 68 + 1, 11, 1)), 32'h31B);

        // Reset state.
        #1 rst = 1'b1;
        step(3);
        check("rst_a", {23'd0, pclk_a, vs_a, hr_a, busy_a, data_a}, 32'd0);
        check("rst_b", {23'd0, pclk_b, vs_b, hr_b, busy_b, data_b}, 32'd0);
        rst = 1'b0;

        // Idle with en=0: pclk runs, everything else stays low.
        toggles = 0;
        prev_pclk = pclk_a;
        for (int k = 0; k < 50; k++) begin
            step(1);
            if (pclk_a != prev_pclk) toggles++;
            prev_pclk = pclk_a;
        end
        check("idle_toggles", 32'(toggles), 32'd50);
        check("idle_quiet", {28'd0, vs_a, hr_a, busy_a, |data_a}, 32'd0);

        // Continuous streaming: long enough for instance B to reach frame 11 row 16.
        en = 1'b1;
        step(33000);
        for (int f = 0; f < 3; f++) begin
            check($sformatf("vsync_periods_f%0d", f), 32'(vs_cnt[f]), 32'd12);
            check($sformatf("href_periods_f%0d", f), 32'(hp_cnt[f]), 32'd24);
            check($sformatf("href_pulses_f%0d", f), 32'(hr_cnt[f]), 32'd3);
            check($sformatf("frame_period_f%0d", f), 32'(rise_cyc[f + 1] - rise_cyc[f]), 32'd144);
        end
        for (int k = 0; k < 8; k++) check($sformatf("f0_row0_byte%0d", k), 32'(f0_bytes[k]), 32'h00);
        for (int k = 0; k < 4; k++) check($sformatf("f1_odd%0d", k), 32'(f1_odd[k]), 32'h01);
        check("b_col16", 32'(b_col16), 32'h01);
        check("b_row16_f11", 32'(b_row16), 32'h1B);
`ifdef OV7670_SENSOR_MODEL_STATUS_EN
        check("done_period0", 32'(done_cyc[1] - done_cyc[0]), 32'd144);
        check("done_period1", 32'(done_cyc[2] - done_cyc[1]), 32'd144);
        for (int f = 0; f < 3; f++) check($sformatf("fcnt_f%0d", f), 32'(fcnt_at_vs[f]), 32'(f));
`endif

        // Drop en while instance A is presenting an active line.
        found = 1'b0;
        for (int k = 0; k < 400 && !found; k++) begin
            step(1);
            if (m_cur[0] >= 2 * 12 && m_cur[0] < 5 * 12) found = 1'b1;
        end
        check("wait_active_drop", 32'(found), 32'd1);
        en = 1'b0;
        after_drop = 1'b1;
        step(400);
        after_drop = 1'b0;
        check("drop_no_vsync", 32'(vs_after), 32'd0);
        check("drop_idle", {31'd0, busy_a}, 32'd0);

        // Re-enable, then a one-cycle reset pulse during an active byte.
        en = 1'b1;
        found = 1'b0;
        for (int k = 0; k < 400 && !found; k++) begin
            step(1);
            if (m_exp[0][9]) found = 1'b1;
        end
        check("wait_href_rst", 32'(found), 32'd1);
        rst = 1'b1;
        #1;
        check("midrst_a", {23'd0, pclk_a, vs_a, hr_a, busy_a, data_a}, 32'd0);
        check("midrst_b", {23'd0, pclk_b, vs_b, hr_b, busy_b, data_b}, 32'd0);
        step(1);
        rst = 1'b0;
        step(400);
        en = 1'b0;
        step(3000);
        check("final_idle", {30'd0, busy_a, busy_b}, 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/ov7670_sensor_model.md
Name: ov7670_sensor_model

Overview:
- Synthesizable OV7670 camera-side transmitter: generates PCLK, VSYNC, HREF and 8-bit RGB444 pixel bytes with a deterministic test pattern.
- Drives the capture path's CMOS inputs for simulation and on-board loopback, with no physical sensor.
- Is the other end of the camera capture interface: timing and byte order match what the capture block receives.

Parameters:
- ACTIVE_COLUMNS, 640, pixels per active line (2 bytes each).
- ACTIVE_ROWS, 480, active lines per frame.
- HBLANK_BYTES, 288, byte times with HREF low after each line's active bytes.
- VSYNC_LINES, 3, lines with VSYNC high.
- VBACK_LINES, 17, blank lines after VSYNC.
- VFRONT_LINES, 10, blank lines after active rows.

Ports:
- clk_i  in  1  system clock
- reset_i  in  1  asynchronous, active-high reset
- en_i  in  1  enable generation; sampled only at frame boundaries
- pclk_o  out  1  pixel clock = clk_i/2, free-running after reset
- vsync_o  out  1  frame sync, active high
- href_o  out  1  line valid, high only during active bytes
- data_o  out  8  pixel byte
- busy_o  out  1  high when state != IDLE

Behaviour:
- Interface: one clock (clk_i); reset_i is asynchronous and active-high.
- Reset values: pclk_o=0, vsync_o=0, href_o=0, data_o=0, busy_o=0. All counters are 0 and the state is IDLE.
- pclk_o toggles every clk_i cycle.
- A "tick" is any cycle in which pclk_o==1.
- All outputs other than pclk_o update only on ticks. They therefore change together with pclk_o falling and are stable for one clk_i cycle before and after each pclk_o rising edge, which is where the receiver samples.
- Line length: LINE_BYTES = 2*ACTIVE_COLUMNS + HBLANK_BYTES byte times.
- Counters:
  - byte_cnt counts 0..LINE_BYTES-1 and wraps.
  - line_cnt counts lines within the current state.
  - frame_cnt is 16 bits, wraps, and increments on VFRONT exit.
- States: IDLE, VSYNC, VBACK, ACTIVE, VFRONT.
  - IDLE -> VSYNC: on a tick with en_i=1.
  - VSYNC -> VBACK: after VSYNC_LINES lines.
  - VBACK -> ACTIVE: after VBACK_LINES lines.
  - ACTIVE -> VFRONT: after ACTIVE_ROWS lines.
  - VFRONT -> VSYNC if en_i=1 at the final tick, else -> IDLE.
- In every state, line_cnt and byte_cnt reset to 0 on each state transition.
- Output latency: the outputs for byte position k are presented in the byte period following the tick at which byte_cnt==k. This is a constant one-tick pipeline, so the first VSYNC byte period begins one pclk period after the IDLE->VSYNC tick.
- vsync_o=1 for every byte period of VSYNC state.
- href_o=1 only in ACTIVE state when byte_cnt < 2*ACTIVE_COLUMNS.
- Pixel pattern:
  - col = byte_cnt>>1, row = line_cnt.
  - R = col[7:4], G = row[7:4], B = frame_cnt[3:0].
  - Even byte_cnt: data_o = {4'h0, R}.
  - Odd byte_cnt: data_o = {G, B}.
- data_o=0 whenever href_o=0.
- en_i deasserted mid-frame: the current frame completes fully, then the block returns to IDLE.
- en_i asserted mid-frame: no effect until a frame boundary.
- reset_i mid-frame: all outputs and state return to reset values immediately, and the partial frame is abandoned.
- Counter widths are sized with $clog2 of their maxima. No overflow is possible.

Optional Feature:
- Macro: OV7670_SENSOR_MODEL_STATUS_EN.
- When defined, adds two ports:
  - frame_done_o (out 1): one-clk_i pulse on the VFRONT exit tick.
  - frame_cnt_o (out 16): the current frame_cnt.
- When undefined, neither port exists. frame_cnt remains internal because the pattern uses it.

Decomposition:
- Package ov7670_sensor_pkg holds:
  - the state enum typedef;
  - the BYTES_PER_PIXEL=2 constant;
  - a function rgb444_byte(col, row, frame, odd) returning the 8-bit pattern byte.
- No sub-module. A single always_ff holds counters/state and a registered output stage.

Test Plan:
All scenarios use ACTIVE_COLUMNS=4, ACTIVE_ROWS=3, HBLANK_BYTES=4, VSYNC_LINES=1, VBACK_LINES=1, VFRONT_LINES=1, which gives LINE_BYTES=12 and a frame of 72 byte times (144 clk_i cycles).
- Reset hold, en_i=0 for 50 cycles -> pclk_o toggles; vsync_o/href_o/data_o/busy_o stay 0.
- en_i=1 continuously -> vsync_o high for exactly 12 pclk periods; HREF pulses exactly 3 per frame, each 8 pclk periods; frame period is 144 clk_i.
- Frame 0, row 0: sampled bytes on pclk rising are 00,00,00,00,00,00,00,00; frame 1 odd bytes are 01.
- ACTIVE_COLUMNS=32: byte at col 16 (even) equals 0x01; row 16 odd byte equals 0x1B when frame_cnt=11.
- en_i dropped mid-ACTIVE -> remaining rows and VFRONT are emitted, then busy_o=0 with no further VSYNC; a 1-cycle reset_i pulse mid-line zeroes outputs within the same cycle.
- OV7670_SENSOR_MODEL_STATUS_EN defined -> frame_done_o pulses once per 144 cycles; frame_cnt_o reads 0,1,2.
